// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequence controller: FSM state encoding,
// default lane geometry and the lane-vector typedef.
package lstm_pkg;

  localparam int unsigned LSTM_DATA_WIDTH = 8;
  localparam int unsigned LSTM_NUM_LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_t;

  typedef logic signed [LSTM_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [LSTM_NUM_LANES-1:0]        lane_vec_t;

endpackage

// File: rtl/lstm_seq_ctrl.sv
// LSTM sequence controller: accepts one input vector at a time, launches the
// core with x(t) and the recurrent h(t-1), captures h(t) and presents it
// downstream. Optional core-timeout watchdog enabled by LSTM_SEQ_TIMEOUT_EN.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = LSTM_DATA_WIDTH,
  parameter int unsigned NUM_LANES      = LSTM_NUM_LANES,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s_x,
  input  logic                            s_first,
  output logic                            core_start,
  output logic [NUM_LANES*DATA_WIDTH-1:0] core_x,
  output logic [NUM_LANES*DATA_WIDTH-1:0] core_y_in,
  input  logic                            core_finished,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] core_y,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] m_y,
  output logic [15:0]                     step_cnt,
  output logic                            err_timeout
);

  seq_state_t                      state;
  logic [NUM_LANES*DATA_WIDTH-1:0] h_state;

`ifdef LSTM_SEQ_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned CW       = $clog2(TO_LIMIT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_reg;
  assign err_timeout = err_reg;
`else
  assign err_timeout = 1'b0;
`endif

  // Handshake/strobe outputs decode directly from the current state.
  always_comb begin
    s_ready    = (state == ST_IDLE);
    core_start = (state == ST_START);
    m_valid    = (state == ST_OUT);
  end

  assign core_y_in = h_state;

  // Step sequencing, data capture and step counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      core_x   <= '0;
      h_state  <= '0;
      m_y      <= '0;
      step_cnt <= '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
      wait_cnt <= '0;
      err_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            core_x <= s_x;
            if (s_first) begin
              h_state  <= '0;
              step_cnt <= '0;
            end
            state <= ST_START;
          end
        end
        ST_START: begin
`ifdef LSTM_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_finished) begin
            m_y      <= core_y;
            h_state  <= core_y;
            step_cnt <= step_cnt + 16'd1;
            state    <= ST_OUT;
          end
`ifdef LSTM_SEQ_TIMEOUT_EN
          // Count reaches TO_LIMIT-1 on the TO_LIMIT-th WAIT cycle.
          else if (wait_cnt == CW'(TO_LIMIT - 1)) begin
            err_reg <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_OUT: begin
          if (m_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
